bcd_time_counter: RTL

Parametrised mm:ss BCD timer, the successor to the fixed stopwatch counter. It has its own one-second prescaler, counts up or down, and accepts a preset load. In up mode it either wraps or saturates at a configurable minute limit. It flags countdown expiry and overflow. It sits between the button/debounce logic and the seven-segment display driver, and feeds the four digit outputs directly to the display mux.

---
 rtl/bcd_time_counter_pkg.sv | 24 ++
 rtl/bcd_time_counter_tick_gen.sv | 26 ++
 rtl/bcd_time_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bcd_time_counter_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_L_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX = 4'd9;

  // Binary value of a two-digit BCD pair (tens, units).
  function automatic int unsigned bcd_pair(bcd_t hi, bcd_t lo);
    int unsigned h;
    int unsigned l;
    h = {28'd0, hi};
    l = {28'd0, lo};
    return h * 10 + l;
  endfunction

endpackage

// File: rtl/bcd_time_counter_tick_gen.sv
// Prescaler: asserts step on the last cycle of each TICK_DIV-cycle period while enabled.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  end

  assign step = en && (cnt == LAST);

endmodule

// File: rtl/bcd_time_counter.sv
// mm:ss BCD up/down timer with preset load, wrap/saturate at MAX_MIN and expiry flags.
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_MIN  = 99,
  parameter bit          WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] ld_min_l,
  input  logic [3:0] ld_min_r,
  input  logic [3:0] ld_sec_l,
  input  logic [3:0] ld_sec_r,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       tick,
  output logic       done,
  output logic       ovf,
  output logic       load_err
);

  localparam bcd_t MAX_ML = 4'(MAX_MIN / 10);
  localparam bcd_t MAX_MR = 4'(MAX_MIN % 10);

  state_t state, state_nx;
  logic   step, clr;
  bcd_t   nml, nmr, nsl, nsr;
  logic   ntick, ndone, novf, nlerr;
  logic   ld_ok, at_max, at_one_or_zero;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == RUNNING),
    .clr  (clr),
    .step (step)
  );

  assign ld_ok = (ld_min_l <= DIGIT_MAX) && (ld_min_r <= DIGIT_MAX) &&
                 (ld_sec_l <= SEC_L_MAX) && (ld_sec_r <= DIGIT_MAX) &&
                 (bcd_pair(ld_min_l, ld_min_r) <= MAX_MIN);

  assign at_max = (min_l == MAX_ML) && (min_r == MAX_MR) &&
                  (sec_l == SEC_L_MAX) && (sec_r == DIGIT_MAX);

  // A down step from 00:01 or 00:00 both land on 00:00 and expire.
  assign at_one_or_zero = (min_l == '0) && (min_r == '0) && (sec_l == '0) && (sec_r <= 4'd1);

  always_comb begin
    nml      = min_l;
    nmr      = min_r;
    nsl      = sec_l;
    nsr      = sec_r;
    ntick    = 1'b0;
    ndone    = 1'b0;
    novf     = 1'b0;
    nlerr    = 1'b0;
    clr      = 1'b0;
    state_nx = (state == EXPIRED) ? EXPIRED : (run ? RUNNING : STOPPED);

    if (load) begin
      clr = 1'b1;
      if (ld_ok) begin
        nml      = ld_min_l;
        nmr      = ld_min_r;
        nsl      = ld_sec_l;
        nsr      = ld_sec_r;
        state_nx = run ? RUNNING : STOPPED;
      end else begin
        nlerr = 1'b1;
      end
    end else if (step) begin
      ntick = 1'b1;
      if (!dir) begin
        if (at_max) begin
          novf = 1'b1;
          if (WRAP) begin
            nml = '0;
            nmr = '0;
            nsl = '0;
            nsr = '0;
          end else begin
            state_nx = EXPIRED;
            clr      = 1'b1;
          end
        end else if (sec_r != DIGIT_MAX) begin
          nsr = sec_r + 4'd1;
        end else begin
          nsr = '0;
          if (sec_l != SEC_L_MAX) begin
            nsl = sec_l + 4'd1;
          end else begin
            nsl = '0;
            if (min_r != DIGIT_MAX) begin
              nmr = min_r + 4'd1;
            end else begin
              nmr = '0;
              nml = min_l + 4'd1;
            end
          end
        end
      end else begin
        if (at_one_or_zero) begin
          nsr      = '0;
          ndone    = 1'b1;
          state_nx = EXPIRED;
          clr      = 1'b1;
        end else if (sec_r != '0) begin
          nsr = sec_r - 4'd1;
        end else begin
          nsr = DIGIT_MAX;
          if (sec_l != '0) begin
            nsl = sec_l - 4'd1;
          end else begin
            nsl = SEC_L_MAX;
            if (min_r != '0) begin
              nmr = min_r - 4'd1;
            end else begin
              nmr = DIGIT_MAX;
              nml = min_l - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= STOPPED;
      min_l    <= '0;
      min_r    <= '0;
      sec_l    <= '0;
      sec_r    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      min_l    <= nml;
      min_r    <= nmr;
      sec_l    <= nsl;
      sec_r    <= nsr;
      tick     <= ntick;
      done     <= ndone;
      ovf      <= novf;
      load_err <= nlerr;
    end
  end

endmodule
